// File: rtl/fp_pkg.sv
// Shared single-precision constants and helpers for the add/sub lane array.
package fp_pkg;
  localparam int FP_W    = 32;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam int LANE_W  = FP_W;

  typedef logic [FP_W-1:0] fp_t;

  localparam fp_t FP_POS_ZERO = 32'h0000_0000;
  localparam fp_t FP_QNAN     = 32'h7FC0_0000;

  // Signed zero of either sign collapses to +0.
  function automatic fp_t fp_canon_zero(input fp_t v);
    return (v[EXP_MSB:0] == '0) ? FP_POS_ZERO : v;
  endfunction
endpackage

// File: rtl/fp_addsub_lanes_if.sv
// Operand/result bundle for fp_addsub_lanes; the DUT uses the slave modport.
interface fp_addsub_lanes_if
  import fp_pkg::*;
#(parameter int LANES = 4);
  logic                    start;
  logic                    in_valid;
  logic [LANES-1:0]        op;
  logic [LANES*FP_W-1:0]   a;
  logic [LANES*FP_W-1:0]   b;
  logic [LANES-1:0]        upd_mask;
  logic [LANES*FP_W-1:0]   result;
  logic                    out_valid;
  logic [LANES*FP_W-1:0]   held_out;
  logic                    busy;
  logic [LANES-1:0]        exc_flag;

  modport master (output start, in_valid, op, a, b, upd_mask,
                  input  result, out_valid, held_out, busy, exc_flag);
  modport slave  (input  start, in_valid, op, a, b, upd_mask,
                  output result, out_valid, held_out, busy, exc_flag);
endinterface

// File: rtl/fp_lane_hold.sv
// One lane: -0 canonicalisation, adder, hold register and optional sticky
// Inf/NaN flag (present only when FP_ADDSUB_EXC_FLAG_EN is defined).
module fp_lane_hold
  import fp_pkg::*;
#(parameter int ADD_LAT = 3) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic out_valid,
  input  logic cap_mask,
  input  logic op,
  input  fp_t  a,
  input  fp_t  b,
  output fp_t  result,
  output fp_t  held_out,
  output logic exc_flag
);
  fp_t  hold_d, hold_q;
  logic capture;

  fpadd #(.LAT(ADD_LAT)) u_fpadd (
    .clk (clk),
    .en  (1'b1),
    .sub (op),
    .a   (fp_canon_zero(a)),
    .b   (fp_canon_zero(b)),
    .y   (result)
  );

  assign capture  = out_valid & cap_mask;
  assign held_out = capture ? result : hold_q;

  // Capture beats the start=0 clear.
  always_comb begin
    hold_d = hold_q;
    if (capture)     hold_d = result;
    else if (!start) hold_d = FP_POS_ZERO;
  end

  // Hold register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= FP_POS_ZERO;
    else        hold_q <= hold_d;
  end

`ifdef FP_ADDSUB_EXC_FLAG_EN
  logic exc_d, exc_q;

  // Sticky flag: set on Inf/NaN exponent, set beats clear.
  always_comb begin
    exc_d = exc_q;
    if (out_valid && (result[EXP_MSB:EXP_LSB] == 8'hFF)) exc_d = 1'b1;
    else if (!start)                                     exc_d = 1'b0;
  end

  // Flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_q <= 1'b0;
    else        exc_q <= exc_d;
  end

  assign exc_flag = exc_q;
`else
  assign exc_flag = 1'b0;
`endif
endmodule

// File: rtl/fpadd.sv
// Pipelined IEEE-754 single-precision adder/subtractor, round-to-nearest-even.
// The full add is computed combinationally and then delayed LAT cycles.
module fpadd
  import fp_pkg::*;
#(parameter int LAT = 3) (
  input  logic clk,
  input  logic en,
  input  logic sub,
  input  fp_t  a,
  input  fp_t  b,
  output fp_t  y
);
  logic        sa, sb, sx, sy, a_nan, b_nan, a_inf, b_inf, up;
  logic [7:0]  ex, ey, d;
  logic [22:0] fx, fy;
  logic [26:0] xa, yf, ya, nrm;
  logic [27:0] sum;
  logic [9:0]  e;
  logic [24:0] rnd;
  fp_t         sum_res, y_c;
  fp_t [LAT-1:0] pipe_d, pipe_q;

  // Align, add, normalise and round; specials override the arithmetic path.
  always_comb begin
    sa    = a[31];
    sb    = b[31] ^ sub;
    a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    if (b[30:0] > a[30:0]) begin
      sx = sb; ex = b[30:23]; fx = b[22:0];
      sy = sa; ey = a[30:23]; fy = a[22:0];
    end else begin
      sx = sa; ex = a[30:23]; fx = a[22:0];
      sy = sb; ey = b[30:23]; fy = b[22:0];
    end
    xa = {ex != 8'd0, fx, 3'b000};
    yf = {ey != 8'd0, fy, 3'b000};
    d  = ((ex == 8'd0) ? 8'd1 : ex) - ((ey == 8'd0) ? 8'd1 : ey);
    if (d >= 8'd27) ya = {26'd0, |yf};
    else            ya = (yf >> d) | {26'd0, |(yf & ((27'd1 << d) - 27'd1))};
    sum = (sx == sy) ? ({1'b0, xa} + {1'b0, ya}) : ({1'b0, xa} - {1'b0, ya});
    e   = {2'b00, (ex == 8'd0) ? 8'd1 : ex};
    if (sum[27]) begin
      nrm = {sum[27:2], sum[1] | sum[0]};
      e   = e + 10'd1;
    end else begin
      nrm = sum[26:0];
    end
    // Left shift stops at exponent 1 so tiny results land as denormals.
    for (int i = 0; i < 26; i++) begin
      if (!nrm[26] && (e > 10'd1)) begin
        nrm = nrm << 1;
        e   = e - 10'd1;
      end
    end
    up  = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
    rnd = {1'b0, nrm[26:3]} + {24'd0, up};
    if (rnd[24]) begin
      rnd = rnd >> 1;
      e   = e + 10'd1;
    end
    if (sum == 28'd0)        sum_res = FP_POS_ZERO;
    else if (e >= 10'd255)   sum_res = {sx, 8'hFF, 23'd0};
    else                     sum_res = {sx, rnd[23] ? e[7:0] : 8'd0, rnd[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) y_c = FP_QNAN;
    else if (a_inf)                                        y_c = {sa, 8'hFF, 23'd0};
    else if (b_inf)                                        y_c = {sb, 8'hFF, 23'd0};
    else                                                   y_c = sum_res;
  end

  // Latency pipeline; data is not reset, only the valid path is.
  always_comb begin
    pipe_d    = pipe_q;
    if (en) begin
      pipe_d[0] = y_c;
      for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  // Register the latency stages.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign y = pipe_q[LAT-1];
endmodule

// File: rtl/fp_addsub_lanes.sv
// LANES parallel fp add/sub lanes with a shared valid/mask pipeline and
// per-lane hold registers. Optional macro: FP_ADDSUB_EXC_FLAG_EN.
module fp_addsub_lanes
  import fp_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int ADD_LAT = 3
) (
  input logic               clk,
  input logic               rst_n,
  fp_addsub_lanes_if.slave  io
);
  logic                              acc;
  logic [ADD_LAT-1:0]                vld_d, vld_q;
  logic [ADD_LAT-1:0][LANES-1:0]     msk_d, msk_q;

  assign acc          = io.in_valid & io.start;
  assign io.out_valid = vld_q[ADD_LAT-1];
  assign io.busy      = |vld_q;

  // Valid and mask shift together so the mask lines up with its result.
  always_comb begin
    vld_d[0] = acc;
    msk_d[0] = acc ? io.upd_mask : '0;
    for (int i = 1; i < ADD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      msk_d[i] = msk_q[i-1];
    end
  end

  // Valid/mask pipeline; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      msk_q <= '0;
    end else begin
      vld_q <= vld_d;
      msk_q <= msk_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    fp_lane_hold #(.ADD_LAT(ADD_LAT)) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (io.start),
      .out_valid (vld_q[ADD_LAT-1]),
      .cap_mask  (msk_q[ADD_LAT-1][g]),
      .op        (io.op[g]),
      .a         (io.a[g*LANE_W +: LANE_W]),
      .b         (io.b[g*LANE_W +: LANE_W]),
      .result    (io.result[g*LANE_W +: LANE_W]),
      .held_out  (io.held_out[g*LANE_W +: LANE_W]),
      .exc_flag  (io.exc_flag[g])
    );
  end
endmodule

// File: tb/tb_fp_addsub_lanes.sv
// Directed bench for fp_addsub_lanes (LANES=4, ADD_LAT=3).
module tb_fp_addsub_lanes;
  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

`ifdef FP_ADDSUB_EXC_FLAG_EN
  localparam logic [3:0] EXC_L2 = 4'b0100;
`else
  localparam logic [3:0] EXC_L2 = 4'b0000;
`endif

  fp_addsub_lanes_if #(.LANES(4)) bus ();

  fp_addsub_lanes #(.LANES(4), .ADD_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rep4(input logic [31:0] v);
    return {v, v, v, v};
  endfunction

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.upd_mask = '0;
    #12;
    chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("rst_busy",      {127'd0, bus.busy},      128'd0);
    chk("rst_held",      bus.held_out,            128'd0);
    chk("rst_exc",       {124'd0, bus.exc_flag},  128'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 1.0 + 2.0 on all lanes, full mask
    bus.start = 1'b1; bus.in_valid = 1'b1;
    bus.a = rep4(32'h3F800000); bus.b = rep4(32'h40000000);
    bus.op = 4'h0; bus.upd_mask = 4'hF;
    tick(1);
    bus.in_valid = 1'b0;
    chk("t1_busy",   {127'd0, bus.busy},      128'd1);
    chk("t1_noval",  {127'd0, bus.out_valid}, 128'd0);
    tick(2);
    chk("t1_valid",  {127'd0, bus.out_valid}, 128'd1);
    chk("t1_result", bus.result,              rep4(32'h40400000));
    chk("t1_held",   bus.held_out,            rep4(32'h40400000));
    tick(1);
    chk("t1_after_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("t1_hold",        bus.held_out,            rep4(32'h40400000));
    chk("t1_idle",        {127'd0, bus.busy},      128'd0);

    // lane0 3.0-1.0 unmasked; lanes1..3 1.5+2.5 masked
    bus.in_valid = 1'b1;
    bus.a = {32'h3FC00000, 32'h3FC00000, 32'h3FC00000, 32'h40400000};
    bus.b = {32'h40200000, 32'h40200000, 32'h40200000, 32'h3F800000};
    bus.op = 4'b0001; bus.upd_mask = 4'b1110;
    tick(1);
    bus.in_valid = 1'b0;
    tick(2);
    chk("t2_valid",   {127'd0, bus.out_valid}, 128'd1);
    chk("t2_result",  bus.result,   {32'h40800000, 32'h40800000, 32'h40800000, 32'h40000000});
    chk("t2_held",    bus.held_out, {32'h40800000, 32'h40800000, 32'h40800000, 32'h40400000});
    tick(1);
    chk("t2_hold",    bus.held_out, {32'h40800000, 32'h40800000, 32'h40800000, 32'h40400000});

    // -0 + -0 must produce +0
    bus.in_valid = 1'b1;
    bus.a = rep4(32'h80000000); bus.b = rep4(32'h80000000);
    bus.op = 4'h0; bus.upd_mask = 4'hF;
    tick(1);
    bus.in_valid = 1'b0;
    tick(2);
    chk("t3_valid",  {127'd0, bus.out_valid}, 128'd1);
    chk("t3_negz",   bus.result,              128'd0);

    // accept then drop start: set completes and is captured, then cleared
    bus.in_valid = 1'b1;
    bus.a = rep4(32'h3F800000); bus.b = rep4(32'h40000000);
    bus.op = 4'h0; bus.upd_mask = 4'hF;
    tick(1);
    bus.in_valid = 1'b0; bus.start = 1'b0;
    tick(2);
    chk("t4_valid",   {127'd0, bus.out_valid}, 128'd1);
    chk("t4_held",    bus.held_out,            rep4(32'h40400000));
    tick(2);
    chk("t4_cleared", bus.held_out,            128'd0);
    chk("t4_idle",    {127'd0, bus.busy},      128'd0);

    // +Inf + 1.0 on lane2 -> exponent all ones; flag sticky until start=0
    bus.start = 1'b1; bus.in_valid = 1'b1;
    bus.a = {32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3F800000};
    bus.b = rep4(32'h40000000);
    bus.b[95:64] = 32'h3F800000;
    bus.op = 4'h0; bus.upd_mask = 4'h0;
    tick(1);
    bus.in_valid = 1'b0;
    tick(2);
    chk("t5_inf_result", bus.result, {32'h40400000, 32'h7F800000, 32'h40400000, 32'h40400000});
    chk("t5_held_nomask", bus.held_out, 128'd0);
    tick(1);
    chk("t5_exc_set", {124'd0, bus.exc_flag}, {124'd0, EXC_L2});
    bus.in_valid = 1'b1;
    bus.a = rep4(32'h3F800000); bus.b = rep4(32'h40000000); bus.upd_mask = 4'hF;
    tick(1);
    bus.in_valid = 1'b0;
    tick(3);
    chk("t5_exc_sticky", {124'd0, bus.exc_flag}, {124'd0, EXC_L2});
    bus.start = 1'b0;
    tick(1);
    chk("t5_exc_clear",  {124'd0, bus.exc_flag}, 128'd0);

    // reset with two sets in flight and a nonzero hold value
    bus.start = 1'b1; bus.in_valid = 1'b1;
    bus.a = rep4(32'h3F800000); bus.b = rep4(32'h40000000); bus.upd_mask = 4'hF;
    tick(1);
    bus.in_valid = 1'b0;
    tick(3);
    chk("t6_hold_pre", bus.held_out, rep4(32'h40400000));
    bus.in_valid = 1'b1;
    tick(2);
    bus.in_valid = 1'b0;
    chk("t6_busy_pre", {127'd0, bus.busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("t6_rst_busy",  {127'd0, bus.busy},      128'd0);
    chk("t6_rst_held",  bus.held_out,            128'd0);
    tick(1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("t6_no_ghost", {127'd0, bus.out_valid}, 128'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
